// File: rtl/block_reg_pkg.sv
// Shared defaults and helpers for the multi-read-port register file.
// Define REGFILE_ZERO_REG_EN to hardwire register 0 to zero (never written, never pending).
package block_reg_pkg;

    localparam int DEF_SIZE_ADDR_REG = 5;
    localparam int DEF_SIZE_REG      = 8;
    localparam int DEF_NB_READ       = 2;

`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZERO_REG_EN = 1'b1;
`else
    localparam bit ZERO_REG_EN = 1'b0;
`endif

    function automatic int nb_reg(input int size_addr_reg);
        return 2 ** size_addr_reg;
    endfunction

    // Widths of the flattened per-port buses.
    function automatic int read_addr_width(input int nb_read, input int size_addr_reg);
        return nb_read * size_addr_reg;
    endfunction

    function automatic int read_data_width(input int nb_read, input int size_reg);
        return nb_read * size_reg;
    endfunction

endpackage

// File: rtl/block_reg_mp_if.sv
// Write/reserve/read bundle of the multi-read-port register file.
interface block_reg_mp_if
    import block_reg_pkg::*;
#(
    parameter int SIZE_ADDR_REG = DEF_SIZE_ADDR_REG,
    parameter int SIZE_REG      = DEF_SIZE_REG,
    parameter int NB_READ       = DEF_NB_READ
);
    localparam int NB_REG = nb_reg(SIZE_ADDR_REG);
    localparam int RA_W   = read_addr_width(NB_READ, SIZE_ADDR_REG);
    localparam int RD_W   = read_data_width(NB_READ, SIZE_REG);

    logic                     write;
    logic [SIZE_ADDR_REG-1:0] addrin;
    logic [SIZE_REG-1:0]      datain;
    logic                     reserve;
    logic [SIZE_ADDR_REG-1:0] reserve_addr;
    logic [NB_READ-1:0]       read_en;
    logic [RA_W-1:0]          read_addr;
    logic [RD_W-1:0]          data_out;
    logic [NB_READ-1:0]       data_valid;
    logic [NB_READ-1:0]       data_pending;
    logic [NB_REG-1:0]        pending;

    modport master (
        output write, addrin, datain, reserve, reserve_addr, read_en, read_addr,
        input  data_out, data_valid, data_pending, pending
    );

    modport slave (
        input  write, addrin, datain, reserve, reserve_addr, read_en, read_addr,
        output data_out, data_valid, data_pending, pending
    );

endinterface

// File: rtl/block_reg_mp_read_port.sv
// One registered read port: write-first bypass, data/valid/pending output registers.
module reg_read_port
    import block_reg_pkg::*;
#(
    parameter int SIZE_ADDR_REG = DEF_SIZE_ADDR_REG,
    parameter int SIZE_REG      = DEF_SIZE_REG
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     read_en,
    input  logic [SIZE_ADDR_REG-1:0] read_addr,
    input  logic [SIZE_REG-1:0]      stored_data,
    input  logic                     stored_pending,
    input  logic                     wr_en,
    input  logic [SIZE_ADDR_REG-1:0] wr_addr,
    input  logic [SIZE_REG-1:0]      wr_data,
    output logic [SIZE_REG-1:0]      data_out,
    output logic                     data_valid,
    output logic                     data_pending
);
    logic                bypass_hit;
    logic [SIZE_REG-1:0] data_next;
    logic                pend_next;
    logic [SIZE_REG-1:0] data_out_reg;
    logic                data_valid_reg;
    logic                data_pending_reg;

    // A same-edge write both supplies the data and clears the pending bit.
    assign bypass_hit = wr_en && (wr_addr == read_addr);
    assign data_next  = bypass_hit ? wr_data : stored_data;
    assign pend_next  = bypass_hit ? 1'b0 : stored_pending;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out_reg     <= '0;
            data_valid_reg   <= 1'b0;
            data_pending_reg <= 1'b0;
        end else begin
            data_valid_reg <= read_en;
            if (read_en) begin
                data_out_reg     <= data_next;
                data_pending_reg <= pend_next;
            end
        end
    end

    assign data_out     = data_out_reg;
    assign data_valid   = data_valid_reg;
    assign data_pending = data_pending_reg;

endmodule

// File: rtl/block_reg_mp.sv
// Edge-triggered register file with NB_READ registered read ports and a pending scoreboard.
// REGFILE_ZERO_REG_EN makes register 0 read as zero and never pending.
module block_reg_mp
    import block_reg_pkg::*;
#(
    parameter int SIZE_ADDR_REG = DEF_SIZE_ADDR_REG,
    parameter int SIZE_REG      = DEF_SIZE_REG,
    parameter int NB_READ       = DEF_NB_READ
) (
    input  logic          clk,
    input  logic          reset,
    block_reg_mp_if.slave bus
);
    localparam int NB_REG = nb_reg(SIZE_ADDR_REG);
    localparam int RD_W   = read_data_width(NB_READ, SIZE_REG);

    logic [SIZE_REG-1:0] regs_reg [NB_REG];
    logic [NB_REG-1:0]   pending_reg;
    logic [NB_REG-1:0]   pending_next;
    logic                wr_en;
    logic                rsv_en;
    logic [RD_W-1:0]     data_out_all;
    logic [NB_READ-1:0]  data_valid_all;
    logic [NB_READ-1:0]  data_pending_all;

    assign wr_en  = bus.write   && !(ZERO_REG_EN && (bus.addrin == '0));
    assign rsv_en = bus.reserve && !(ZERO_REG_EN && (bus.reserve_addr == '0));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NB_REG; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (wr_en) begin
            regs_reg[bus.addrin] <= bus.datain;
        end
    end

    // Clear first, then set: a new producer supersedes a completing one.
    always_comb begin
        pending_next = pending_reg;
        if (wr_en) begin
            pending_next[bus.addrin] = 1'b0;
        end
        if (rsv_en) begin
            pending_next[bus.reserve_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_reg <= '0;
        end else begin
            pending_reg <= pending_next;
        end
    end

    generate
        for (genvar gi = 0; gi < NB_READ; gi++) begin : g_port
            logic [SIZE_ADDR_REG-1:0] port_addr;
            logic [SIZE_REG-1:0]      port_data;
            logic                     port_valid;
            logic                     port_pend;

            assign port_addr = bus.read_addr[gi*SIZE_ADDR_REG +: SIZE_ADDR_REG];

            reg_read_port #(
                .SIZE_ADDR_REG (SIZE_ADDR_REG),
                .SIZE_REG      (SIZE_REG)
            ) u_port (
                .clk            (clk),
                .reset          (reset),
                .read_en        (bus.read_en[gi]),
                .read_addr      (port_addr),
                .stored_data    (regs_reg[port_addr]),
                .stored_pending (pending_reg[port_addr]),
                .wr_en          (wr_en),
                .wr_addr        (bus.addrin),
                .wr_data        (bus.datain),
                .data_out       (port_data),
                .data_valid     (port_valid),
                .data_pending   (port_pend)
            );

            assign data_out_all[gi*SIZE_REG +: SIZE_REG] = port_data;
            assign data_valid_all[gi]                    = port_valid;
            assign data_pending_all[gi]                  = port_pend;
        end
    endgenerate

    assign bus.data_out     = data_out_all;
    assign bus.data_valid   = data_valid_all;
    assign bus.data_pending = data_pending_all;
    assign bus.pending      = pending_reg;

endmodule

// File: tb/tb_block_reg_mp.sv
// Randomised bench for block_reg_mp against an array/vector reference model.
module tb_block_reg_mp;

    localparam int SA = 5;
    localparam int SR = 8;
    localparam int NR = 2;
    localparam int NB = 2 ** SA;

`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZERO = 1'b1;
`else
    localparam bit ZERO = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    block_reg_mp_if #(.SIZE_ADDR_REG(SA), .SIZE_REG(SR), .NB_READ(NR)) bus ();

    block_reg_mp #(.SIZE_ADDR_REG(SA), .SIZE_REG(SR), .NB_READ(NR)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Reference model state
    logic [SR-1:0] mem [NB];
    logic [NB-1:0] pend;
    logic [SR-1:0] exp_out [NR];
    logic [NR-1:0] exp_valid;
    logic [NR-1:0] exp_dp;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NB; i++) mem[i] = '0;
        pend = '0;
        for (int p = 0; p < NR; p++) exp_out[p] = '0;
        exp_valid = '0;
        exp_dp = '0;
    endtask

    task automatic set_idle();
        bus.write = 1'b0;
        bus.addrin = '0;
        bus.datain = '0;
        bus.reserve = 1'b0;
        bus.reserve_addr = '0;
        bus.read_en = '0;
        bus.read_addr = '0;
    endtask

    task automatic set_read(input int p, input logic [SA-1:0] a);
        bus.read_en[p] = 1'b1;
        bus.read_addr[p*SA +: SA] = a;
    endtask

    task automatic compare_all();
        check_eq("data_valid", bus.data_valid, exp_valid);
        for (int p = 0; p < NR; p++) begin
            check_eq($sformatf("data_out[%0d]", p), bus.data_out[p*SR +: SR], exp_out[p]);
        end
        check_eq("data_pending", bus.data_pending, exp_dp);
        check_eq("pending", bus.pending, pend);
    endtask

    // One clock: predict from pre-edge inputs, let the edge happen, commit and compare.
    task automatic tick();
        logic [SR-1:0] nx_out [NR];
        logic [NR-1:0] nx_dp;
        logic [SA-1:0] ra;
        logic          w, r;
        logic [SA-1:0] wa, rsa;
        logic [SR-1:0] wd;
        w = bus.write; wa = bus.addrin; wd = bus.datain;
        r = bus.reserve; rsa = bus.reserve_addr;
        for (int p = 0; p < NR; p++) begin
            nx_out[p] = exp_out[p];
            nx_dp[p]  = exp_dp[p];
            if (bus.read_en[p]) begin
                ra = bus.read_addr[p*SA +: SA];
                if (ZERO && ra == 0) begin
                    nx_out[p] = '0; nx_dp[p] = 1'b0;
                end else if (w && wa == ra) begin
                    nx_out[p] = wd; nx_dp[p] = 1'b0;
                end else begin
                    nx_out[p] = mem[ra]; nx_dp[p] = pend[ra];
                end
            end
        end
        exp_valid = bus.read_en;
        @(posedge clk);
        #1;
        cyc++;
        for (int p = 0; p < NR; p++) exp_out[p] = nx_out[p];
        exp_dp = nx_dp;
        if (w && !(ZERO && wa == 0)) mem[wa] = wd;
        if (w) pend[wa] = 1'b0;
        if (r && !(ZERO && rsa == 0)) pend[rsa] = 1'b1;
        $display("cyc %0d w=%0b a=%0d d=%h rsv=%0b ra=%0d ren=%b raddr=%h out=%h v=%b dp=%b",
                 cyc, w, wa, wd, r, rsa, exp_valid, bus.read_addr, bus.data_out,
                 bus.data_valid, bus.data_pending);
        compare_all();
        @(negedge clk);
    endtask

    task automatic randomize_inputs();
        bus.write = 1'($urandom_range(0, 1));
        bus.addrin = ($urandom_range(0, 1) != 0) ? SA'($urandom_range(0, 7)) : SA'($urandom);
        bus.datain = SR'($urandom);
        bus.reserve = ($urandom_range(0, 3) == 0);
        bus.reserve_addr = ($urandom_range(0, 1) != 0) ? SA'($urandom_range(0, 7)) : SA'($urandom);
        bus.read_en = NR'($urandom);
        for (int p = 0; p < NR; p++) begin
            bus.read_addr[p*SA +: SA] = ($urandom_range(0, 1) != 0) ? SA'($urandom_range(0, 7)) : SA'($urandom);
        end
    endtask

    initial begin
        set_idle();
        model_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        compare_all();
        reset = 1'b1;

        // Write then dual-port read
        bus.write = 1'b1; bus.addrin = 5'd7; bus.datain = 8'hA5;
        tick();
        set_idle(); set_read(0, 5'd7); set_read(1, 5'd7);
        tick();
        check_eq("wr_rd_p0", bus.data_out[0 +: SR], 8'hA5);
        check_eq("wr_rd_p1", bus.data_out[SR +: SR], 8'hA5);
        check_eq("wr_rd_valid", bus.data_valid, 2'b11);

        // Write-first bypass on port 1
        set_idle(); bus.write = 1'b1; bus.addrin = 5'd12; bus.datain = 8'h3C; set_read(1, 5'd12);
        tick();
        check_eq("bypass_p1", bus.data_out[SR +: SR], 8'h3C);
        check_eq("bypass_dp", bus.data_pending[1], 1'b0);

        // Scoreboard reserve / complete
        set_idle(); bus.reserve = 1'b1; bus.reserve_addr = 5'd9;
        tick();
        set_idle(); set_read(0, 5'd9);
        tick();
        check_eq("rsv_dp", bus.data_pending[0], 1'b1);
        set_idle(); bus.write = 1'b1; bus.addrin = 5'd9; bus.datain = 8'h11;
        tick();
        check_eq("clr_pend9", bus.pending[9], 1'b0);
        set_idle(); set_read(0, 5'd9);
        tick();
        check_eq("rd9_data", bus.data_out[0 +: SR], 8'h11);
        check_eq("rd9_dp", bus.data_pending[0], 1'b0);

        // Same-edge reserve and write: set wins, data lands
        set_idle(); bus.reserve = 1'b1; bus.reserve_addr = 5'd4;
        bus.write = 1'b1; bus.addrin = 5'd4; bus.datain = 8'h77;
        tick();
        check_eq("coll_pend4", bus.pending[4], 1'b1);
        set_idle(); set_read(1, 5'd4);
        tick();
        check_eq("coll_data4", bus.data_out[SR +: SR], 8'h77);

        // Register 0
        set_idle(); bus.write = 1'b1; bus.addrin = 5'd0; bus.datain = 8'hFF;
        bus.reserve = 1'b1; bus.reserve_addr = 5'd0;
        tick();
        check_eq("zero_pend0", bus.pending[0], ZERO ? 1'b0 : 1'b1);
        set_idle(); set_read(0, 5'd0);
        tick();
        check_eq("zero_data", bus.data_out[0 +: SR], ZERO ? 8'h00 : 8'hFF);

        // Random burst with an asynchronous reset in the middle
        for (int i = 0; i < 400; i++) begin
            randomize_inputs();
            tick();
            if (i == 200) begin
                randomize_inputs();
                bus.read_en = '1;
                #2;
                reset = 1'b0;
                #1;
                model_reset();
                check_eq("arst_data_out", bus.data_out, '0);
                check_eq("arst_valid", bus.data_valid, '0);
                check_eq("arst_dp", bus.data_pending, '0);
                check_eq("arst_pending", bus.pending, '0);
                @(posedge clk);
                #1;
                compare_all();
                @(negedge clk);
                reset = 1'b1;
                set_idle(); set_read(0, 5'd3);
                tick();
                check_eq("post_rst_rd3", bus.data_out[0 +: SR], 8'h00);
                check_eq("post_rst_v", bus.data_valid[0], 1'b1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
